// File: rtl/button_debounce_if.sv
// Button bundle between the raw pins and the conditioned outputs.
// The DUT takes the slave modport; whoever drives the pins takes master.
interface button_debounce_if #(
  parameter int unsigned NUM_BUTTONS = 4
);
  logic [NUM_BUTTONS-1:0] n_button;
  logic [NUM_BUTTONS-1:0] button_state;
  logic [NUM_BUTTONS-1:0] button_press;
  logic [NUM_BUTTONS-1:0] button_release;
  logic [NUM_BUTTONS-1:0] button_long;

  modport master (
    output n_button,
    input  button_state,
    input  button_press,
    input  button_release,
    input  button_long
  );

  modport slave (
    input  n_button,
    output button_state,
    output button_press,
    output button_release,
    output button_long
  );
endinterface

// File: rtl/button_debounce.sv
// Per-button conditioner: 2-flop synchroniser, debounce FSM and long-press timer per channel.
// All outputs are registered; strobes are single-cycle.
module button_debounce #(
  parameter int unsigned NUM_BUTTONS       = 4,
  parameter int unsigned DEBOUNCE_CYCLES   = 50000,
  parameter int unsigned LONG_PRESS_CYCLES = 25000000
) (
  input logic               main_clk,
  input logic               n_rst,
  button_debounce_if.slave  btn
);

  localparam int unsigned DebW  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HoldW = (LONG_PRESS_CYCLES > 0) ? $clog2(LONG_PRESS_CYCLES + 1) : 1;

  localparam logic [DebW-1:0]  DebLast = DebW'(DEBOUNCE_CYCLES - 2);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(LONG_PRESS_CYCLES);
  localparam logic [HoldW-1:0] LongAt  = HoldW'(LONG_PRESS_CYCLES - 1);
  localparam logic             LongEn  = (LONG_PRESS_CYCLES != 0);

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StPressed,
    StReleaseWait
  } state_e;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    logic             s1_q, s2_q;
    logic             raw;
    state_e           st_q, st_d;
    logic [DebW-1:0]  dcnt_q, dcnt_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             long_q, long_d;

    assign raw = ~s2_q;

    always_ff @(posedge main_clk or negedge n_rst) begin
      if (!n_rst) begin
        s1_q    <= 1'b1;
        s2_q    <= 1'b1;
        st_q    <= StIdle;
        dcnt_q  <= '0;
        hold_q  <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
      end else begin
        s1_q    <= btn.n_button[i];
        s2_q    <= s1_q;
        st_q    <= st_d;
        dcnt_q  <= dcnt_d;
        hold_q  <= hold_d;
        level_q <= level_d;
        press_q <= press_d;
        rel_q   <= rel_d;
        long_q  <= long_d;
      end
    end

    always_comb begin
      st_d    = st_q;
      dcnt_d  = dcnt_q;
      hold_d  = hold_q;
      level_d = level_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      long_d  = 1'b0;
      unique case (st_q)
        StIdle: begin
          if (raw) begin
            st_d   = StPressWait;
            dcnt_d = '0;
          end
        end
        StPressWait: begin
          if (!raw) begin
            st_d = StIdle;
          end else if (dcnt_q == DebLast) begin
            st_d    = StPressed;
            level_d = 1'b1;
            press_d = 1'b1;
            hold_d  = '0;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
        StPressed: begin
          // Saturation at the threshold keeps the long strobe to one per press.
          if (hold_q != HoldMax) hold_d = hold_q + 1'b1;
          if (LongEn && (hold_q == LongAt)) long_d = 1'b1;
          if (!raw) begin
            st_d   = StReleaseWait;
            dcnt_d = '0;
          end
        end
        StReleaseWait: begin
          if (raw) begin
            st_d = StPressed;
          end else if (dcnt_q == DebLast) begin
            st_d    = StIdle;
            level_d = 1'b0;
            rel_d   = 1'b1;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
        default: st_d = StIdle;
      endcase
    end

    assign btn.button_state[i]   = level_q;
    assign btn.button_press[i]   = press_q;
    assign btn.button_release[i] = rel_q;
    assign btn.button_long[i]    = long_q;
  end

endmodule
